uart_bus_master: RTL
====================

// Module: uart_bus_master
// PURPOSE
//  Host-side initiator for the memory-mapped peripheral bus. Takes bytes from the UART
//  receiver, decodes read/write command frames, wins the bus from the CPU via req/gnt,
//  issues one bus cycle, and returns read data or an ack byte to the UART transmitter.
//  Used for board bring-up, loading and debug without CPU software.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max idle clk cycles between frame bytes before the frame is discarded
//  ACK_BYTE        8'h4B      'K', returned after a completed write
//  NAK_BYTE        8'h4E      'N', returned on a rejected address (only with the macro below)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high
//  rx_data    in   8   received byte
//  rx_valid   in   1   one-cycle pulse, rx_data valid
//  tx_data    out  8   byte to transmit
//  tx_valid   out  1   tx_data valid; held until tx_ready
//  tx_ready   in   1   transmitter accepts tx_data this cycle when tx_valid&tx_ready
//  bus_req    out  1   request for peripheral bus ownership
//  bus_gnt    in   1   CPU arbiter grant
//  rd         out  1   bus read strobe
//  wr         out  1   bus write strobe
//  addr       out  32  bus address
//  wdata      out  32  bus write data
//  rdata      in   32  bus read data, combinational from addr/rd
//  busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; tx_valid, bus_req, rd, wr, busy = 0; tx_data, addr, wdata = 0; byte counter and timeout = 0.
//  Frames, multi-byte fields MSB first:
//   read  : 8'h52 'R', A3 A2 A1 A0            -> reply D3 D2 D1 D0
//   write : 8'h57 'W', A3..A0, D3..D0         -> reply ACK_BYTE
//  Any other command byte in IDLE is dropped; state stays IDLE.
//  States: IDLE -> ADDR (4 bytes) -> [WDATA (4 bytes) if write] -> REQ -> BUS -> RESP -> IDLE.
//  ADDR/WDATA: shift one byte per rx_valid; 2-bit byte counter; move on after the 4th byte.
//  REQ: bus_req=1; wait for bus_gnt with no limit. BUS is entered the cycle after bus_gnt is seen high.
//  BUS: exactly one cycle; rd or wr =1, addr/wdata stable; rdata latched at the end of that cycle.
//   Release bus_req on the next cycle.
//  RESP: 1 byte (write) or 4 bytes (read, MSB first). Each byte is presented with tx_valid=1 and
//   held until tx_valid&tx_ready; the next byte is presented on the following cycle. Return to IDLE after the last byte.
//  Timeout: in ADDR/WDATA, counter clears on each rx_valid. When it reaches TIMEOUT_CYCLES:
//   frame discarded, -> IDLE, no reply, no bus cycle.
//  rx_valid in REQ/BUS/RESP is ignored; the byte is lost. No queueing.
//  rd and wr are never high in the same cycle. Neither strobe is ever high without bus_gnt.
//  If bus_gnt drops in BUS, the strobe still completes that cycle; the arbiter must hold the grant while bus_req=1.
//  reset in any state: immediate return to reset values. An in-flight strobe is deasserted the next cycle.
// CONFIGURATION
//  BUS_MASTER_ADDR_CHECK_EN defined: after the 4th address byte, addresses outside
//   32'h4000_0000..32'h4000_FFFF are rejected.
//   Write: the 4 data bytes are still consumed. Read and write: no bus_req, no strobe;
//   the reply is the single byte NAK_BYTE.
//  Not defined: every address is forwarded to the bus unchanged.
// TESTING
//  1 Write: 57 40 00 00 0C 00 00 00 A5, gnt 2 cycles after req -> one wr pulse, addr=4000000C, wdata=000000A5; tx 4B.
//  2 Read: 52 40 00 00 10, rdata=12345678 -> one rd pulse at 40000010; tx 12 34 56 78 in order.
//    tx_ready stalls 5 cycles per byte: tx_data held steady while stalled.
//  3 Garbage: 00 FF 41, then valid read -> first three bytes ignored; read completes normally.
//  4 Timeout: 57 40 00, then silence for TIMEOUT_CYCLES (bench sets it to 16) -> IDLE, no wr, no tx.
//    A following full read succeeds.
//  5 Reset asserted in REQ with gnt low -> next cycle: bus_req=0, busy=0; no strobe is ever issued.
//  6 Macro defined: 52 00 00 00 00 -> no bus_req, tx 4E. Same frame without macro -> rd at 00000000, 4 bytes returned.

Source files
------------

// File: rtl/uart_bus_master.sv
// -----------------------------------------------------------------------------
// uart_bus_master
//
// Host-side bus initiator driven by a UART byte stream. Decodes read ('R')
// and write ('W') command frames (multi-byte fields MSB first), requests the
// peripheral bus from the CPU arbiter, issues exactly one bus cycle and
// returns either the four read data bytes or a single ack byte.
//
//   read  : 52 A3 A2 A1 A0            -> reply D3 D2 D1 D0
//   write : 57 A3 A2 A1 A0 D3..D0     -> reply ACK_BYTE
//
// Optional feature, macro BUS_MASTER_ADDR_CHECK_EN:
//   when defined, addresses outside 32'h4000_0000..32'h4000_FFFF are rejected
//   after the 4th address byte. A write still consumes its 4 data bytes.
//   A rejected frame never requests the bus and is answered with NAK_BYTE.
//   When not defined, every address is forwarded to the bus unchanged.
//
// Parameters
//   TIMEOUT_CYCLES : idle cycles allowed between frame bytes
//   ACK_BYTE       : reply to a completed write
//   NAK_BYTE       : reply to a rejected address (address check builds only)
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   rx_data/valid   : received byte, one-cycle valid pulse
//   tx_data/valid   : byte to transmit, held until tx_ready
//   tx_ready        : transmitter accepts the byte when tx_valid & tx_ready
//   bus_req/bus_gnt : bus ownership request / arbiter grant
//   rd, wr          : one-cycle bus strobes
//   addr, wdata     : bus address / write data
//   rdata           : bus read data, combinational from addr/rd
//   busy            : high whenever the FSM is not in IDLE
//
// Transmit handshake: a byte transfers on every rising edge where tx_valid and
// tx_ready are both high. Once tx_valid is raised, tx_valid and tx_data stay
// constant until that transfer; the next byte appears the cycle after.
// -----------------------------------------------------------------------------
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  NAK_BYTE       = 8'h4E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;

  // Counter only has to count up to TIMEOUT_CYCLES-1 before the frame drops.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_REQ,
    S_BUS,
    S_RESP
  } state_t;

  state_t        state;
  state_t        next_state;

  logic          is_write;     // current frame is a write
  logic          nak;          // write frame whose address was rejected
  logic [1:0]    byte_cnt;     // field byte index within ADDR / WDATA
  logic [TW-1:0] timeout_cnt;  // idle cycles since last frame byte
  logic [23:0]   resp_sr;      // remaining read-reply bytes, MSB first
  logic [1:0]    resp_left;    // reply bytes still to send after tx_data

  logic [31:0]   addr_next;
  logic          timeout_hit;
  logic          reject;
  logic          tx_fire;
  logic          is_cmd;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    addr_next   = {addr[23:0], rx_data};
    timeout_hit = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
    tx_fire     = tx_valid && tx_ready;
    is_cmd      = (rx_data == CMD_READ) || (rx_data == CMD_WRITE);
`ifdef BUS_MASTER_ADDR_CHECK_EN
    reject      = (addr_next[31:16] != 16'h4000);
`else
    reject      = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (rx_valid && is_cmd) next_state = S_ADDR;
      end
      S_ADDR: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) begin
            if (is_write)    next_state = S_WDATA;
            else if (reject) next_state = S_RESP;
            else             next_state = S_REQ;
          end
        end else if (timeout_hit) begin
          next_state = S_IDLE;
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) next_state = nak ? S_RESP : S_REQ;
        end else if (timeout_hit) begin
          next_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus_gnt) next_state = S_BUS;
      end
      S_BUS: begin
        next_state = S_RESP;
      end
      S_RESP: begin
        if (tx_fire && (resp_left == 2'd0)) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      bus_req     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      busy        <= 1'b0;
      is_write    <= 1'b0;
      nak         <= 1'b0;
      byte_cnt    <= '0;
      timeout_cnt <= '0;
      resp_sr     <= '0;
      resp_left   <= '0;
    end else begin
      busy    <= (next_state != S_IDLE);
      // bus_req covers REQ and the single BUS cycle, so it drops in RESP.
      bus_req <= (next_state == S_REQ) || (next_state == S_BUS);
      // BUS is only reachable after bus_gnt was seen, so strobes never
      // precede the grant.
      rd      <= (next_state == S_BUS) && !is_write;
      wr      <= (next_state == S_BUS) &&  is_write;

      case (state)
        S_IDLE: begin
          if (rx_valid && is_cmd) begin
            is_write    <= (rx_data == CMD_WRITE);
            nak         <= 1'b0;
            byte_cnt    <= '0;
            timeout_cnt <= '0;
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            addr        <= addr_next;
            byte_cnt    <= byte_cnt + 2'd1;
            timeout_cnt <= '0;
            if ((byte_cnt == 2'd3) && reject) begin
              if (is_write) begin
                nak <= 1'b1;
              end else begin
                tx_data   <= NAK_BYTE;
                tx_valid  <= 1'b1;
                resp_left <= 2'd0;
              end
            end
          end else if (timeout_hit) begin
            timeout_cnt <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
        end

        S_WDATA: begin
          if (rx_valid) begin
            wdata       <= {wdata[23:0], rx_data};
            byte_cnt    <= byte_cnt + 2'd1;
            timeout_cnt <= '0;
            if ((byte_cnt == 2'd3) && nak) begin
              tx_data   <= NAK_BYTE;
              tx_valid  <= 1'b1;
              resp_left <= 2'd0;
            end
          end else if (timeout_hit) begin
            timeout_cnt <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
        end

        S_BUS: begin
          // rdata is sampled at the end of the strobe cycle.
          tx_valid <= 1'b1;
          if (is_write) begin
            tx_data   <= ACK_BYTE;
            resp_left <= 2'd0;
          end else begin
            tx_data   <= rdata[31:24];
            resp_sr   <= rdata[23:0];
            resp_left <= 2'd3;
          end
        end

        S_RESP: begin
          if (tx_fire) begin
            if (resp_left == 2'd0) begin
              tx_valid <= 1'b0;
            end else begin
              tx_data   <= resp_sr[23:16];
              resp_sr   <= {resp_sr[15:0], 8'h00};
              resp_left <= resp_left - 2'd1;
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule
